dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package: data-memory defaults, responder FSM states
// and the address legality check used by the load/store responder.
package cpu_pkg;

  localparam int DMEM_DEPTH_DW = 128;
  localparam int DMEM_LATENCY  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Misaligned (not a doubleword boundary) or beyond the array.
  function automatic logic dmem_addr_err(
    input logic [63:0] addr,
    input int          depth
  );
    logic mis;
    logic oor;
    mis = (addr[2:0] != 3'd0);
    oor = (addr[63:3] >= 61'(depth));
    return mis | oor;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage: one synchronous write port, one combinational
// read port. Ports: clk, we_i/waddr_i/wdata_i, raddr_i -> rdata_o.
module dmem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH_DW = DMEM_DEPTH_DW,
  parameter int AW       = (DEPTH_DW > 1) ? $clog2(DEPTH_DW) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [63:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o
);

  // Contents start at zero and are never touched by reset.
  logic [63:0] mem_q [DEPTH_DW] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with fixed access latency.
// Ports: clk, reset (async low), req_* handshake in, rsp_* handshake out.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH_DW = DMEM_DEPTH_DW,
  parameter int LATENCY  = DMEM_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_DW > 1) ? $clog2(DEPTH_DW) : 1;

  dmem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic          write_q;
  logic          err_q;
  logic [63:0]   wdata_q;
  logic [63:0]   rdata_q, rdata_d;
  logic          rerr_q, rerr_d;

  logic          accept;
  logic          mem_we;
  logic [63:0]   mem_rdata;

  assign req_ready = (state_q == ST_IDLE) & reset;
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      idx_q   <= req_addr[AW+2:3];
      write_q <= req_write;
      err_q   <= dmem_addr_err(req_addr, DEPTH_DW);
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Access happens on the edge that enters RESP.
          mem_we  = write_q & ~err_q;
          rdata_d = (write_q | err_q) ? 64'd0 : mem_rdata;
          rerr_d  = err_q;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          rerr_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  dmem_array #(
    .DEPTH_DW (DEPTH_DW),
    .AW       (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default build (LATENCY=2) plus
// a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  logic        clk;
  logic        reset;

  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  logic        req_valid1, req_ready1, req_write1;
  logic [63:0] req_addr1, req_wdata1;
  logic        rsp_valid1, rsp_err1;
  logic [63:0] rsp_rdata1;

  int vecs = 0;
  int errs = 0;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(.DEPTH_DW(128), .LATENCY(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid1),
    .req_ready (req_ready1),
    .req_write (req_write1),
    .req_addr  (req_addr1),
    .req_wdata (req_wdata1),
    .rsp_valid (rsp_valid1),
    .rsp_ready (1'b1),
    .rsp_rdata (rsp_rdata1),
    .rsp_err   (rsp_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on dut, wait for its response (no handshake).
  task automatic do_req(input string tag, input logic w,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic [63:0] erd, input logic ee);
    int n;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    chk({tag, "_rdy"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd2);
    chk({tag, "_data"}, rsp_rdata, erd);
    chk({tag, "_err"}, 64'(rsp_err), 64'(ee));
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_hs_vld"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_hs_rdy"}, 64'(req_ready), 64'd1);
  endtask

  logic [63:0] ref1 [128];
  logic [63:0] expq [$];
  logic        op_w   [14];
  int          op_idx [14];
  logic [63:0] op_d   [14];

  initial begin
    req_valid  = 0; req_write  = 0; req_addr  = 0; req_wdata  = 0;
    rsp_ready  = 0;
    req_valid1 = 0; req_write1 = 0; req_addr1 = 0; req_wdata1 = 0;
    reset = 1'b0;
    #2;
    chk("rst_rdy", 64'(req_ready), 64'd0);
    chk("rst_vld", 64'(rsp_valid), 64'd0);
    chk("rst_data", rsp_rdata, 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("post_rst_rdy", 64'(req_ready), 64'd1);

    // Store then load to the same doubleword.
    do_req("st10", 1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0);
    handshake("st10");
    do_req("ld10", 1'b0, 64'h10, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0);
    handshake("ld10");

    // Misaligned load, then its neighbour still reads zero.
    do_req("ld0c", 1'b0, 64'h0C, 64'd0, 64'd0, 1'b1);
    handshake("ld0c");
    do_req("ld08", 1'b0, 64'h08, 64'd0, 64'd0, 1'b0);
    handshake("ld08");

    // Out-of-range store must not alias into the array.
    do_req("st400", 1'b1, 64'h400, 64'hFFFF_0000_FFFF_0000, 64'd0, 1'b1);
    handshake("st400");
    do_req("ld00", 1'b0, 64'h0, 64'd0, 64'd0, 1'b0);
    handshake("ld00");
    do_req("ld10b", 1'b0, 64'h10, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0);

    // Stall in RESP with req_valid toggling.
    req_write = 1'b1;
    req_addr  = 64'h18;
    req_wdata = 64'h5555;
    for (int i = 0; i < 5; i++) begin
      req_valid = ~req_valid;
      @(posedge clk); #1;
      chk("hold_vld", 64'(rsp_valid), 64'd1);
      chk("hold_data", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
      chk("hold_rdy", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    handshake("hold");
    do_req("ld18", 1'b0, 64'h18, 64'd0, 64'd0, 1'b0);
    handshake("ld18");

    // Reset during WAIT drops a pending store.
    do_req("st20", 1'b1, 64'h20, 64'h1111, 64'd0, 1'b0);
    handshake("st20");
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = 64'h2222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rstw_vld", 64'(rsp_valid), 64'd0);
    chk("rstw_rdy", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    do_req("ld20", 1'b0, 64'h20, 64'd0, 64'h1111, 1'b0);

    // Reset while a load response is held clears outputs at once.
    #2 reset = 1'b0;
    #1;
    chk("rstr_vld", 64'(rsp_valid), 64'd0);
    chk("rstr_data", rsp_rdata, 64'd0);
    chk("rstr_err", 64'(rsp_err), 64'd0);
    chk("rstr_rdy", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    do_req("ld20b", 1'b0, 64'h20, 64'd0, 64'h1111, 1'b0);
    handshake("ld20b");

    // LATENCY=1 instance: 4 stores then 10 loads, back to back.
    for (int i = 0; i < 128; i++) ref1[i] = '0;
    op_w[0] = 1; op_idx[0] = 5;   op_d[0] = 64'hA5A5_0000_0000_0005;
    op_w[1] = 1; op_idx[1] = 9;   op_d[1] = 64'h0123_4567_89AB_CDEF;
    op_w[2] = 1; op_idx[2] = 2;   op_d[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    op_w[3] = 1; op_idx[3] = 127; op_d[3] = 64'h8000_0000_0000_0001;
    op_idx[4]  = 5;   op_idx[5]  = 9;  op_idx[6]  = 2;
    op_idx[7]  = 127; op_idx[8]  = 0;  op_idx[9]  = 9;
    op_idx[10] = 3;   op_idx[11] = 2;  op_idx[12] = 5;
    op_idx[13] = 127;
    for (int i = 4; i < 14; i++) begin
      op_w[i] = 0;
      op_d[i] = '0;
    end

    begin
      int k, cyc, last, nrsp;
      logic acc;
      k = 0; cyc = 0; last = -1; nrsp = 0;
      req_valid1 = 1'b1;
      req_write1 = op_w[0];
      req_addr1  = 64'(op_idx[0]) << 3;
      req_wdata1 = op_d[0];
      while (nrsp < 14 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        acc = 1'b0;
        if (rsp_valid1) begin
          if (expq.size() > 0) begin
            chk("l1_data", rsp_rdata1, expq.pop_front());
          end else begin
            chk("l1_extra_rsp", 64'd1, 64'd0);
          end
          chk("l1_err", 64'(rsp_err1), 64'd0);
          nrsp++;
        end
        if (req_ready1 && req_valid1) begin
          if (last >= 0) chk("l1_gap", 64'(cyc - last), 64'd3);
          last = cyc;
          if (op_w[k]) begin
            ref1[op_idx[k]] = op_d[k];
            expq.push_back(64'd0);
          end else begin
            expq.push_back(ref1[op_idx[k]]);
          end
          k++;
          acc = 1'b1;
        end
        @(posedge clk); #1;
        if (acc) begin
          if (k < 14) begin
            req_write1 = op_w[k];
            req_addr1  = 64'(op_idx[k]) << 3;
            req_wdata1 = op_d[k];
          end else begin
            req_valid1 = 1'b0;
          end
        end
      end
      chk("l1_rsp_count", 64'(nrsp), 64'd14);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
